// File: rtl/alu_mon_pkg.sv
// Shared constants for the ALU trojan monitor: opcodes, FSM
// encoding and the width of one logged mismatch entry.
package alu_mon_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_MONITOR = 2'b01;
    localparam logic [1:0] ST_ALARM   = 2'b10;

    // {op, a, b, res, cout}
    localparam int LOG_W = 15;

endpackage

// File: rtl/alu_trojan_monitor_golden.sv
// alu_golden: combinational reference ALU for the monitor.
// Ports: op, a, b in; exp_res, exp_cout out (carry/borrow).
module alu_golden
    import alu_mon_pkg::*;
(
    input  logic [1:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] exp_res,
    output logic       exp_cout
);

    always_comb begin
        exp_res  = '0;
        exp_cout = 1'b0;
        unique case (op)
            OP_ADD: {exp_cout, exp_res} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                exp_res  = a - b;
                exp_cout = (a < b);
            end
            OP_AND: exp_res = a & b;
            OP_OR:  exp_res = a | b;
        endcase
    end

endmodule

// File: rtl/alu_trojan_monitor.sv
// alu_trojan_monitor: checks each ALU transaction against alu_golden,
// counts mismatches, captures the first one and raises a sticky alarm.
// Ports: clk, rst (sync, high), en, clear, valid_in, op, a, b, res,
// cout in; mismatch, alarm, txn_cnt, mis_cnt, cap_*, state out.
// ALU_MON_LOG_EN adds a 4-entry mismatch FIFO: log_pop in;
// log_data, log_empty, log_full, log_ovf (sticky) out.
module alu_trojan_monitor
    import alu_mon_pkg::*;
#(
    parameter int ALARM_THRESH = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [1:0]       op,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [3:0]       res,
    input  logic             cout,
`ifdef ALU_MON_LOG_EN
    input  logic             log_pop,
    output logic [LOG_W-1:0] log_data,
    output logic             log_empty,
    output logic             log_full,
    output logic             log_ovf,
`endif
    output logic             mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    output logic [1:0]       cap_op,
    output logic [3:0]       cap_a,
    output logic [3:0]       cap_b,
    output logic [3:0]       cap_res,
    output logic             cap_cout,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [3:0]       s1_a;
    logic [3:0]       s1_b;
    logic [3:0]       s1_res;
    logic             s1_cout;
    logic [3:0]       exp_res;
    logic             exp_cout;
    logic             sample;
    logic             hit;
    logic             captured;
    logic [CNT_W-1:0] mis_nxt;
    logic [1:0]       state_nxt;

    alu_golden u_golden (
        .op       (s1_op),
        .a        (s1_a),
        .b        (s1_b),
        .exp_res  (exp_res),
        .exp_cout (exp_cout)
    );

    assign sample = valid_in &&
                    (state == ST_MONITOR || state == ST_ALARM);
    assign hit    = s1_valid &&
                    (s1_res != exp_res || s1_cout != exp_cout);
    assign alarm  = (state == ST_ALARM);

    always_comb begin
        mis_nxt = mis_cnt;
        if (hit && mis_cnt != CNT_MAX)
            mis_nxt = mis_cnt + CNT_W'(1);
    end

    // Reaching the threshold wins over en falling in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (en) state_nxt = ST_MONITOR;
            ST_MONITOR: begin
                if (hit && mis_nxt >= THRESH) state_nxt = ST_ALARM;
                else if (!en)                 state_nxt = ST_IDLE;
            end
            ST_ALARM:   state_nxt = ST_ALARM;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= ST_IDLE;
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_res   <= '0;
            s1_cout  <= 1'b0;
            mismatch <= 1'b0;
            txn_cnt  <= '0;
            mis_cnt  <= '0;
            captured <= 1'b0;
            cap_op   <= '0;
            cap_a    <= '0;
            cap_b    <= '0;
            cap_res  <= '0;
            cap_cout <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1_valid <= sample;
            if (sample) begin
                s1_op   <= op;
                s1_a    <= a;
                s1_b    <= b;
                s1_res  <= res;
                s1_cout <= cout;
            end
            mismatch <= hit;
            mis_cnt  <= mis_nxt;
            if (s1_valid && txn_cnt != CNT_MAX)
                txn_cnt <= txn_cnt + CNT_W'(1);
            if (hit && !captured) begin
                captured <= 1'b1;
                cap_op   <= s1_op;
                cap_a    <= s1_a;
                cap_b    <= s1_b;
                cap_res  <= s1_res;
                cap_cout <= s1_cout;
            end
        end
    end

`ifdef ALU_MON_LOG_EN
    logic [LOG_W-1:0] fifo [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       count;
    logic             pop;
    logic             do_push;

    // A full FIFO still accepts a push when a pop frees a slot.
    assign pop       = log_pop && count != 3'd0;
    assign do_push   = hit && (count != 3'd4 || pop);
    assign log_data  = fifo[rd_ptr];
    assign log_empty = (count == 3'd0);
    assign log_full  = (count == 3'd4);

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear)
            fifo[wr_ptr] <= {s1_op, s1_a, s1_b, s1_res, s1_cout};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            if (hit && !do_push) log_ovf <= 1'b1;
            count <= count + 3'(do_push) - 3'(pop);
        end
    end
`endif

endmodule

// File: tb/tb_alu_trojan_monitor.sv
// Self-checking bench for alu_trojan_monitor: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_alu_trojan_monitor;
    import alu_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, clear, valid_in;
    logic [1:0] op;
    logic [3:0] a, b, res;
    logic       cout;
    logic       mismatch, alarm;
    logic [7:0] txn_cnt, mis_cnt;
    logic [1:0] cap_op;
    logic [3:0] cap_a, cap_b, cap_res;
    logic       cap_cout;
    logic [1:0] state;
`ifdef ALU_MON_LOG_EN
    logic        log_pop;
    logic [14:0] log_data;
    logic        log_empty, log_full, log_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_trojan_monitor #(.ALARM_THRESH(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .valid_in(valid_in), .op(op), .a(a), .b(b),
        .res(res), .cout(cout),
`ifdef ALU_MON_LOG_EN
        .log_pop(log_pop), .log_data(log_data),
        .log_empty(log_empty), .log_full(log_full),
        .log_ovf(log_ovf),
`endif
        .mismatch(mismatch), .alarm(alarm),
        .txn_cnt(txn_cnt), .mis_cnt(mis_cnt),
        .cap_op(cap_op), .cap_a(cap_a), .cap_b(cap_b),
        .cap_res(cap_res), .cap_cout(cap_cout), .state(state)
    );

    // Reference ALU from plain integer arithmetic; returns {cout,res}.
    function automatic logic [4:0] ref_alu(input int o, input int x,
                                           input int y);
        int r, c;
        case (o)
            0: begin r = (x + y) % 16; c = (x + y > 15) ? 1 : 0; end
            1: begin r = (x - y + 16) % 16; c = (x < y) ? 1 : 0; end
            2: begin r = x & y; c = 0; end
            default: begin r = x | y; c = 0; end
        endcase
        return {c[0], r[3:0]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [3:0] x,
                         input logic [3:0] y, input logic [3:0] r,
                         input logic c);
        valid_in = 1'b1; op = o; a = x; b = y; res = r; cout = c;
    endtask

    task automatic do_clear;
        valid_in = 1'b0; clear = 1'b1;
        step;
        clear = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        n_tests++;
        if ({state, mismatch, alarm, txn_cnt, mis_cnt} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d mis=%b alm=%b txn=%0d mc=%0d, required all 0",
                     state, mismatch, alarm, txn_cnt, mis_cnt);
        end
        n_tests++;
        if ({cap_op, cap_a, cap_b, cap_res, cap_cout} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_cap: got %h, required 0",
                     {cap_op, cap_a, cap_b, cap_res, cap_cout});
        end
`ifdef ALU_MON_LOG_EN
        n_tests++;
        if (log_empty !== 1'b1 || log_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_log: empty=%b ovf=%b, required 1/0",
                     log_empty, log_ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed;
        en = 1'b1;
        step;
        n_tests++;
        if (state !== ST_MONITOR) begin
            n_fail++;
            $display("FAIL idle_to_monitor: state=%0d, required 1", state);
        end
        drive(OP_ADD, 4'd5, 4'd3, 4'd8, 1'b0);
        step;
        valid_in = 1'b0;
        step;
        n_tests++;
        if ({mismatch, txn_cnt, mis_cnt, state} !== {1'b0, 8'd1, 8'd0, ST_MONITOR}) begin
            n_fail++;
            $display("FAIL add_ok: mis=%b txn=%0d mc=%0d st=%0d, required 0/1/0/1",
                     mismatch, txn_cnt, mis_cnt, state);
        end
        drive(OP_ADD, 4'd15, 4'd15, 4'd15, 1'b0);
        step;
        valid_in = 1'b0;
        step;
        n_tests++;
        if ({mismatch, mis_cnt, alarm, state} !== {1'b1, 8'd1, 1'b1, ST_ALARM}) begin
            n_fail++;
            $display("FAIL add_bad: mis=%b mc=%0d alm=%b st=%0d, required 1/1/1/2",
                     mismatch, mis_cnt, alarm, state);
        end
        n_tests++;
        if ({cap_op, cap_a, cap_b, cap_res, cap_cout} !== {2'd0, 4'd15, 4'd15, 4'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL first_cap: got %h, required %h",
                     {cap_op, cap_a, cap_b, cap_res, cap_cout},
                     {2'd0, 4'd15, 4'd15, 4'd15, 1'b0});
        end
        step;
        n_tests++;
        if (mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: mis=%b, required 0", mismatch);
        end
        en = 1'b0;
        drive(OP_ADD, 4'd9, 4'd6, 4'd5, 1'b1);
        step;
        valid_in = 1'b0;
        step;
        n_tests++;
        if ({mismatch, mis_cnt, alarm} !== {1'b1, 8'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL alarm_counts: mis=%b mc=%0d alm=%b, required 1/2/1",
                     mismatch, mis_cnt, alarm);
        end
        n_tests++;
        if ({cap_op, cap_a, cap_b, cap_res, cap_cout} !== {2'd0, 4'd15, 4'd15, 4'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL cap_hold: got %h, required %h",
                     {cap_op, cap_a, cap_b, cap_res, cap_cout},
                     {2'd0, 4'd15, 4'd15, 4'd15, 1'b0});
        end
        drive(OP_SUB, 4'd3, 4'd5, 4'd14, 1'b1);
        step;
        valid_in = 1'b0;
        step;
        n_tests++;
        if ({mismatch, mis_cnt, txn_cnt} !== {1'b0, 8'd2, 8'd4}) begin
            n_fail++;
            $display("FAIL sub_ok: mis=%b mc=%0d txn=%0d, required 0/2/4",
                     mismatch, mis_cnt, txn_cnt);
        end
    endtask

    task automatic test_en_drop;
        do_clear;
        en = 1'b1;
        step;
        drive(OP_OR, 4'd5, 4'd10, 4'd15, 1'b0);
        step;
        valid_in = 1'b0;
        en = 1'b0;
        step;
        n_tests++;
        if ({txn_cnt, mismatch, state} !== {8'd1, 1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL en_drop: txn=%0d mis=%b st=%0d, required 1/0/0",
                     txn_cnt, mismatch, state);
        end
    endtask

    task automatic test_random;
        int m_txn, m_mis;
        bit pend_v, pend_m, capd, v, bad;
        logic [14:0] m_cap, pend_e;
        logic [1:0] o;
        logic [3:0] x, y;
        logic [4:0] g, act;
        do_clear;
        en = 1'b1;
        step;
        m_txn = 0; m_mis = 0; capd = 0; m_cap = '0;
        pend_v = 0; pend_m = 0; pend_e = '0;
        for (int i = 0; i <= 200; i++) begin
            v = (i < 200) && ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 3) == 0);
            o = 2'($urandom_range(0, 3));
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            g = ref_alu(int'(o), int'(x), int'(y));
            act = bad ? (g ^ 5'($urandom_range(1, 31))) : g;
            valid_in = v; op = o; a = x; b = y;
            res = act[3:0]; cout = act[4];
            step;
            if (pend_v) m_txn++;
            if (pend_m) begin
                m_mis++;
                if (!capd) begin capd = 1; m_cap = pend_e; end
            end
            n_tests++;
            if ({mismatch, txn_cnt, mis_cnt} !== {pend_m, 8'(m_txn), 8'(m_mis)}) begin
                n_fail++;
                $display("FAIL rand_cyc%0d: mis=%b txn=%0d mc=%0d, required %b/%0d/%0d",
                         i, mismatch, txn_cnt, mis_cnt, pend_m, m_txn, m_mis);
            end
            n_tests++;
            if (alarm !== (m_mis >= 1)) begin
                n_fail++;
                $display("FAIL rand_alarm%0d: alm=%b, required %b",
                         i, alarm, (m_mis >= 1));
            end
            pend_v = v;
            pend_m = v && bad;
            pend_e = {o, x, y, act[3:0], act[4]};
        end
        valid_in = 1'b0;
        n_tests++;
        if ({cap_op, cap_a, cap_b, cap_res, cap_cout} !== m_cap) begin
            n_fail++;
            $display("FAIL rand_cap: got %h, required %h",
                     {cap_op, cap_a, cap_b, cap_res, cap_cout}, m_cap);
        end
    endtask

    task automatic test_saturation;
        do_clear;
        en = 1'b1;
        step;
        for (int i = 0; i < 300; i++) begin
            drive(OP_ADD, 4'd1, 4'd1, 4'd0, 1'b0);
            step;
        end
        valid_in = 1'b0;
        step;
        step;
        n_tests++;
        if ({mis_cnt, txn_cnt} !== {8'd255, 8'd255}) begin
            n_fail++;
            $display("FAIL saturate: mc=%0d txn=%0d, required 255/255",
                     mis_cnt, txn_cnt);
        end
        drive(OP_AND, 4'd12, 4'd10, 4'd0, 1'b0);
        step;
        valid_in = 1'b0;
        clear = 1'b1;
        step;
        clear = 1'b0;
        n_tests++;
        if ({mismatch, state, mis_cnt, txn_cnt} !== {1'b0, ST_IDLE, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL clear_prio: mis=%b st=%0d mc=%0d txn=%0d, required 0/0/0/0",
                     mismatch, state, mis_cnt, txn_cnt);
        end
        step;
        n_tests++;
        if ({mismatch, mis_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL clear_flush: mis=%b mc=%0d, required 0/0",
                     mismatch, mis_cnt);
        end
    endtask

    task automatic test_rst_mid;
        do_clear;
        en = 1'b1;
        step;
        drive(OP_SUB, 4'd2, 4'd7, 4'd0, 1'b0);
        step;
        valid_in = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        en = 1'b0;
        n_tests++;
        if ({mismatch, alarm, state, txn_cnt, mis_cnt} !== 20'd0 ||
            {cap_op, cap_a, cap_b, cap_res, cap_cout} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_mid: mis=%b alm=%b st=%0d txn=%0d mc=%0d, required all 0",
                     mismatch, alarm, state, txn_cnt, mis_cnt);
        end
        step;
        n_tests++;
        if (mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flush: mis=%b, required 0", mismatch);
        end
    endtask

`ifdef ALU_MON_LOG_EN
    task automatic test_log;
        logic [14:0] q [$];
        logic [3:0] x;
        do_clear;
        en = 1'b1;
        step;
        for (int i = 0; i < 5; i++) begin
            x = 4'(i + 2);
            drive(OP_AND, x, 4'd15, 4'(~x), 1'b0);
            q.push_back({OP_AND, x, 4'd15, 4'(~x), 1'b0});
            step;
        end
        valid_in = 1'b0;
        step;
        n_tests++;
        if ({log_full, log_ovf} !== 2'b11) begin
            n_fail++;
            $display("FAIL log_full_ovf: full=%b ovf=%b, required 1/1",
                     log_full, log_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (log_data !== q[i]) begin
                n_fail++;
                $display("FAIL log_pop%0d: data=%h, required %h",
                         i, log_data, q[i]);
            end
            log_pop = 1'b1;
            step;
            log_pop = 1'b0;
        end
        log_pop = 1'b1;
        step;
        log_pop = 1'b0;
        n_tests++;
        if ({log_empty, log_full, log_ovf} !== 3'b101) begin
            n_fail++;
            $display("FAIL log_empty: empty=%b full=%b ovf=%b, required 1/0/1",
                     log_empty, log_full, log_ovf);
        end
        do_clear;
        n_tests++;
        if (log_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL log_clear: ovf=%b, required 0", log_ovf);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; valid_in = 1'b0;
        op = '0; a = '0; b = '0; res = '0; cout = 1'b0;
`ifdef ALU_MON_LOG_EN
        log_pop = 1'b0;
`endif
        test_reset;
        test_directed;
        test_en_drop;
        test_random;
        test_saturation;
        test_rst_mid;
`ifdef ALU_MON_LOG_EN
        test_log;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
